// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sequence generator: FSM states, default sizes
// and the pattern-length clamp.
package seqgen_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int REP_W_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requested lengths beyond the register size transmit the whole register.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seqgen_shifter.sv
// Loadable MSB-first shift register with down-counting bit counter; 'last' flags
// the final bit of the loaded pattern.
module seqgen_shifter
  import seqgen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int CNT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               serial,
  output logic               last
);

  logic [MAX_LEN-1:0] sreg;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W-1:0]   lsh;

  // Left-align the active bits so pattern[len-1] lands in the MSB.
  always_comb lsh = LEN_W'(MAX_LEN) - len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= pattern << lsh;
      cnt  <= CNT_W'(len - LEN_W'(1));
    end else if (shift && (cnt != '0)) begin
      sreg <= sreg << 1;
      cnt  <= cnt - CNT_W'(1);
    end
  end

  assign serial = sreg[MAX_LEN-1];
  assign last   = (cnt == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial frame generator: transmits a captured pattern MSB-first, repeat_n times, with an
// optional even-parity trailer (SEQGEN_PARITY_EN). The serial bit port is 'seq' ('sequence' is reserved).
module sequence_generator
  import seqgen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int REP_W   = REP_W_DEF,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   repeat_n,
  output logic               seq,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [REP_W-1:0]   rep_cnt;
  logic [LEN_W-1:0]   len_c;
  logic [REP_W-1:0]   rep_c;
  logic [MAX_LEN-1:0] ld_pat;
  logic [LEN_W-1:0]   ld_len;
  logic               ld, sh, accept, rep_dec;
  logic               serial, last;
`ifdef SEQGEN_PARITY_EN
  logic               par_acc;
`endif

  always_comb begin
    len_c = LEN_W'(clamp_len(32'(len), MAX_LEN));
    rep_c = (repeat_n == '0) ? REP_W'(1) : repeat_n;
  end

  seqgen_shifter #(.MAX_LEN(MAX_LEN)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .shift   (sh),
    .pattern (ld_pat),
    .len     (ld_len),
    .serial  (serial),
    .last    (last)
  );

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    sh        = 1'b0;
    accept    = 1'b0;
    rep_dec   = 1'b0;
    seq       = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ld_pat    = pat_q;
    ld_len    = len_q;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          ld_pat = pattern;
          ld_len = len_c;
          if (len_c == '0) begin
            state_nxt = DONE;
          end else begin
            ld        = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        valid = 1'b1;
        busy  = 1'b1;
        seq   = serial;
        if (!last) begin
          sh = 1'b1;
        end else if (rep_cnt != '0) begin
          // Reload the captured pattern on the last bit so repetitions run back-to-back.
          ld      = 1'b1;
          rep_dec = 1'b1;
        end else begin
`ifdef SEQGEN_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SEQGEN_PARITY_EN
      PAR: begin
        valid     = 1'b1;
        busy      = 1'b1;
        seq       = par_acc;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        pat_q   <= pattern;
        len_q   <= len_c;
        rep_cnt <= rep_c - REP_W'(1);
      end else if (rep_dec) begin
        rep_cnt <= rep_cnt - REP_W'(1);
      end
    end
  end

`ifdef SEQGEN_PARITY_EN
  // XOR of every transmitted bit; sending it makes the frame's total ones count even.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_acc <= 1'b0;
    end else if (accept) begin
      par_acc <= 1'b0;
    end else if (state == SHIFT) begin
      par_acc <= par_acc ^ serial;
    end
  end
`endif

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter REP_W, default 4: width of the repeat count.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to begin a frame; sampled only in IDLE.
REQ-006 SHALL have port pattern  input  MAX_LEN  bit pattern to transmit; captured at start.
REQ-007 SHALL have port len  input  $clog2(MAX_LEN+1)  active pattern length; captured at start.
REQ-008 SHALL have port repeat_n  input  REP_W  number of pattern repetitions; captured at start.
REQ-009 SHALL have port sequence  output  1  serial data bit.
REQ-010 SHALL have port valid  output  1  high when sequence carries a frame bit.
REQ-011 SHALL have port busy  output  1  high from the first bit through the last bit of a frame.
REQ-012 SHALL have port done  output  1  one-cycle pulse after a frame completes.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT, PAR and DONE.
REQ-014 SHALL accept start only in IDLE, and SHALL ignore start in SHIFT, PAR and DONE without side effects.
REQ-015 SHALL capture pattern, len and repeat_n on the start edge, so that input changes mid-frame have no effect.
REQ-016 SHALL drive the first bit one cycle after start is sampled (IDLE->SHIFT), with valid=1 and busy=1.
REQ-017 SHALL transmit bits MSB-first over the active length: pattern[len-1] down to pattern[0], one bit per cycle.
REQ-018 SHALL repeat the captured pattern back-to-back repeat_n times, with no idle cycle between repetitions.
REQ-019 SHALL treat repeat_n=0 as 1.
REQ-020 SHALL clamp len>MAX_LEN to MAX_LEN.
REQ-021 SHALL handle len=0 as follows: IDLE->DONE, with no valid bits, busy never asserted, and done pulsed one cycle after start.
REQ-022 SHALL, after the last bit (or after PAR when enabled), enter DONE for exactly one cycle with done=1, busy=0 and valid=0, then return to IDLE.
REQ-023 SHALL hold sequence=0 whenever valid=0.
REQ-024 SHALL count bits using a bit counter of width $clog2(MAX_LEN) and a repetition counter of width REP_W, with no wrap beyond the captured values.

Reset
REQ-025 SHALL, while rst=0 (asynchronously, including mid-frame), force the state to IDLE, clear all counters and captured registers, and drive sequence=0, valid=0, busy=0 and done=0.
REQ-026 SHALL not emit a done pulse for a frame aborted by reset.
REQ-027 SHALL sample start on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, when SEQGEN_PARITY_EN is defined, enter PAR after each full frame (all repetitions) and emit one even-parity bit over all transmitted frame bits, with valid=1 and busy=1, before entering DONE.
REQ-029 SHALL, when SEQGEN_PARITY_EN is undefined, have no PAR state, a parity accumulator that is absent from the design, and go from SHIFT directly to DONE.
REQ-030 SHALL, when SEQGEN_PARITY_EN is defined and len=0, emit no parity bit.

Structure
REQ-031 SHALL place the FSM state enum, the default MAX_LEN and REP_W, and the length-clamp helper in a shared package, seqgen_pkg.
REQ-032 SHALL implement the loadable MSB-first shift register plus bit counter as one sub-module, seqgen_shifter, with load, shift, last-bit flag and serial out.
REQ-033 SHALL keep the FSM, repeat counter and optional parity in sequence_generator.

Verification
REQ-034 SHALL check: pattern=8'b0000_1011, len=4, repeat_n=1, start at cycle 0 -> sequence 1,0,1,1 with valid=1 in cycles 1-4, and done=1 in cycle 5.
REQ-035 SHALL check: pattern=8'b0000_0110, len=3, repeat_n=3 -> 110110110 over cycles 1-9 contiguously, done in cycle 10, and busy=1 only in cycles 1-9.
REQ-036 SHALL check: start held high through a frame, and pattern changed at cycle 2 -> the frame is unaffected and a second frame begins no earlier than the cycle after DONE.
REQ-037 SHALL check: rst driven low at cycle 3 of an 8-bit frame -> outputs are 0 immediately (asynchronously), no done pulse occurs, and a restart transmits the full new frame.
REQ-038 SHALL check: len=0, start -> done in cycle 1, with valid and busy never high; len=12 -> transmits 8 bits.
REQ-039 SHALL check, with SEQGEN_PARITY_EN defined: pattern=4'b1011, len=4, repeat_n=1 -> bits 1,0,1,1 then parity bit 1, and done in cycle 6.
